debounce_scheduler: RTL and testbench

- Debounces N_BTN push-buttons with one shared stability counter, so the counter is not replicated per button.
- Each button gets a 2-FF synchronizer.
- A round-robin scheduler hands the shared counter to one button at a time whose synchronized level differs from its debounced level.
- Sits between the board button pins and the VGA control logic (mode/colour select). Outputs are clean levels plus one-cycle press/release strobes.

---
 rtl/debounce_scheduler_if.sv | 35 +++
 rtl/debounce_scheduler.sv | 125 ++++++++++++
 tb/tb_debounce_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/debounce_scheduler_if.sv
// Button-debouncer bus: raw pins in, clean levels/strobes/debug out.
// With DBNC_EVENT_CNT_EN defined the bus also carries o_press_count.
interface debounce_scheduler_if #(
  parameter int N_BTN = 4,
  parameter int CW    = 8
);
  localparam int IW = (N_BTN > 1) ? $clog2(N_BTN) : 1;

  logic [N_BTN-1:0] i_boton;
  logic [N_BTN-1:0] o_salida;
  logic [N_BTN-1:0] o_press;
  logic [N_BTN-1:0] o_release;
  logic             o_busy;
  logic [IW-1:0]    o_idx;
  logic [CW-1:0]    o_conteo;
`ifdef DBNC_EVENT_CNT_EN
  logic [7:0]       o_press_count;
`endif

  modport master (
`ifdef DBNC_EVENT_CNT_EN
    input  o_press_count,
`endif
    output i_boton,
    input  o_salida, o_press, o_release, o_busy, o_idx, o_conteo
  );

  modport slave (
`ifdef DBNC_EVENT_CNT_EN
    output o_press_count,
`endif
    input  i_boton,
    output o_salida, o_press, o_release, o_busy, o_idx, o_conteo
  );
endinterface

// File: rtl/debounce_scheduler.sv
// N-button debouncer sharing one stability counter via a round-robin scheduler.
// Optional DBNC_EVENT_CNT_EN adds a saturating count of committed presses.
module debounce_scheduler #(
  parameter int N_BTN = 4,
  parameter int IMM   = 200,
  parameter int CW    = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  debounce_scheduler_if.slave bus
);
  localparam int IW = (N_BTN > 1) ? $clog2(N_BTN) : 1;
  localparam logic [1:0] S_SCAN   = 2'd0;
  localparam logic [1:0] S_COUNT  = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;
  localparam logic [CW-1:0] LAST  = CW'(IMM - 1);

  logic [N_BTN-1:0] r_sync1, r_sync2;
  logic [N_BTN-1:0] r_salida, r_press, r_release;
  logic [1:0]       r_state;
  logic [IW-1:0]    r_idx, r_ptr;
  logic [CW-1:0]    r_conteo;
`ifdef DBNC_EVENT_CNT_EN
  logic [7:0]       r_press_count;
`endif

  logic [N_BTN-1:0] w_mism;
  logic             w_found;
  logic [IW-1:0]    w_pick;
  logic [IW-1:0]    w_next;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign w_mism = r_sync2 ^ r_salida;
  assign w_next = (r_idx == IW'(N_BTN - 1)) ? '0 : r_idx + IW'(1);

  // Scan from highest offset down so the offset nearest r_ptr wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int j = N_BTN - 1; j >= 0; j--) begin
      int k;
      k = int'(r_ptr) + j;
      if (k >= N_BTN) k = k - N_BTN;
      if (w_mism[IW'(k)]) begin
        w_found = 1'b1;
        w_pick  = IW'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_salida  <= '0;
      r_press   <= '0;
      r_release <= '0;
      r_state   <= S_SCAN;
      r_idx     <= '0;
      r_ptr     <= '0;
      r_conteo  <= '0;
`ifdef DBNC_EVENT_CNT_EN
      r_press_count <= '0;
`endif
    end else begin
      r_sync1   <= bus.i_boton;
      r_sync2   <= r_sync1;
      r_press   <= '0;
      r_release <= '0;
      case (r_state)
        S_SCAN: begin
          if (w_found) begin
            r_idx    <= w_pick;
            r_conteo <= '0;
            r_state  <= S_COUNT;
          end
        end
        S_COUNT: begin
          // Owner bounced back to its committed level: give up the counter.
          if (!w_mism[r_idx]) begin
            r_conteo <= '0;
            r_ptr    <= w_next;
            r_state  <= S_SCAN;
          end else if (r_conteo == LAST) begin
            r_state  <= S_COMMIT;
          end else begin
            r_conteo <= r_conteo + CW'(1);
          end
        end
        S_COMMIT: begin
          r_salida[r_idx] <= ~r_salida[r_idx];
          if (r_salida[r_idx]) begin
            r_release[r_idx] <= 1'b1;
          end else begin
            r_press[r_idx] <= 1'b1;
`ifdef DBNC_EVENT_CNT_EN
            r_press_count <= sat_inc8(r_press_count);
`endif
          end
          r_ptr    <= w_next;
          r_conteo <= '0;
          r_state  <= S_SCAN;
        end
        default: begin
          r_conteo <= '0;
          r_state  <= S_SCAN;
        end
      endcase
    end
  end

  assign bus.o_salida  = r_salida;
  assign bus.o_press   = r_press;
  assign bus.o_release = r_release;
  assign bus.o_busy    = (r_state != S_SCAN);
  assign bus.o_idx     = r_idx;
  assign bus.o_conteo  = r_conteo;
`ifdef DBNC_EVENT_CNT_EN
  assign bus.o_press_count = r_press_count;
`endif

endmodule

// File: tb/tb_debounce_scheduler.sv
// Bench for debounce_scheduler: directed scenarios plus random pin activity,
// checked against an age-based reference model of the scheduling rules.
module tb_debounce_scheduler;
  localparam int N   = 4;
  localparam int IMM = 4;
  localparam int CW  = 8;
  localparam int IW  = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  debounce_scheduler_if #(.N_BTN(N), .CW(CW)) bus();
  debounce_scheduler #(.N_BTN(N), .IMM(IMM), .CW(CW)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: an owner is claimed at edge m_start, must stay mismatched
  // for IMM further edges, and its level flips on edge m_start+IMM+1.
  logic [N-1:0] m_s1, m_s2, m_sal, m_press, m_rel;
  int m_owner, m_start, m_ptr, m_last, m_conteo, m_edge, m_pcnt;

  function automatic void model_reset();
    m_s1 = '0; m_s2 = '0; m_sal = '0; m_press = '0; m_rel = '0;
    m_owner = -1; m_start = 0; m_ptr = 0; m_last = 0; m_conteo = 0;
    m_edge = 0; m_pcnt = 0;
  endfunction

  function automatic void model_edge(input logic [N-1:0] pin);
    logic [N-1:0] mism;
    int age, k;
    bit found;
    m_edge++;
    mism = m_s2 ^ m_sal;
    m_press = '0;
    m_rel   = '0;
    if (m_owner < 0) begin
      found = 0;
      for (int j = 0; j < N; j++) begin
        k = (m_ptr + j) % N;
        if (!found && mism[k]) begin
          found = 1; m_owner = k; m_last = k; m_start = m_edge; m_conteo = 0;
        end
      end
    end else begin
      age = m_edge - m_start;
      if (age == IMM + 1) begin
        if (m_sal[m_owner]) m_rel[m_owner] = 1'b1;
        else begin
          m_press[m_owner] = 1'b1;
          if (m_pcnt < 255) m_pcnt++;
        end
        m_sal[m_owner] = ~m_sal[m_owner];
        m_ptr = (m_owner + 1) % N; m_owner = -1; m_conteo = 0;
      end else if (!mism[m_owner]) begin
        m_ptr = (m_owner + 1) % N; m_owner = -1; m_conteo = 0;
      end else begin
        m_conteo = (age < IMM - 1) ? age : IMM - 1;
      end
    end
    m_s2 = m_s1;
    m_s1 = pin;
  endfunction

  function automatic logic [3*N+CW:0] exp_vec();
    return {m_sal, m_press, m_rel, (m_owner >= 0), CW'(m_conteo)};
  endfunction

  function automatic logic [3*N+CW:0] got_vec();
    return {bus.o_salida, bus.o_press, bus.o_release, bus.o_busy, bus.o_conteo};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_edge(bus.i_boton);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.i_boton = '0;
    model_reset();
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.i_boton = '1;
    model_reset();
    #1;
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (got_vec() !== '0 || bus.o_idx !== '0) begin
        n_fail++;
        $display("FAIL reset c%0d: got %h idx %0d, required 0", c, got_vec(), bus.o_idx);
      end
`ifdef DBNC_EVENT_CNT_EN
      n_checks++;
      if (bus.o_press_count !== 8'd0) begin
        n_fail++;
        $display("FAIL reset_pcnt: got %0d, required 0", bus.o_press_count);
      end
`endif
      tick();
    end
    bus.i_boton = '0;
    reset_n = 1'b1;
  endtask

  task automatic test_single_press();
    do_reset();
    bus.i_boton = 4'b0001;
    for (int e = 1; e <= 12; e++) begin
      tick();
      n_checks++;
      if (got_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL single e%0d: got %h required %h", e, got_vec(), exp_vec());
      end
      n_checks++;
      if (bus.o_press !== ((e == 8) ? 4'b0001 : 4'b0000) || bus.o_release !== 4'b0000
          || bus.o_salida[0] !== (e >= 8)) begin
        n_fail++;
        $display("FAIL single_strobe e%0d: press %b release %b salida %b", e,
                 bus.o_press, bus.o_release, bus.o_salida);
      end
    end
  endtask

  task automatic test_bounce();
    int rel;
    do_reset();
    for (int e = 1; e <= 20; e++) begin
      bus.i_boton = (e <= 3 || e >= 6) ? 4'b0010 : 4'b0000;
      tick();
      rel = e - 5;  // final rise is sampled on e=6, i.e. rel=1
      n_checks++;
      if (got_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL bounce e%0d: got %h required %h", e, got_vec(), exp_vec());
      end
      n_checks++;
      if (bus.o_press !== ((rel == 8) ? 4'b0010 : 4'b0000)) begin
        n_fail++;
        $display("FAIL bounce_press e%0d: got %b required %b", e, bus.o_press,
                 (rel == 8) ? 4'b0010 : 4'b0000);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [N-1:0] ep;
    do_reset();
    bus.i_boton = 4'b0110;
    for (int e = 1; e <= 16; e++) begin
      tick();
      ep = (e == 8) ? 4'b0010 : (e == 14) ? 4'b0100 : 4'b0000;
      n_checks++;
      if (got_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL simul e%0d: got %h required %h", e, got_vec(), exp_vec());
      end
      n_checks++;
      if (bus.o_press !== ep) begin
        n_fail++;
        $display("FAIL simul_press e%0d: got %b required %b", e, bus.o_press, ep);
      end
      if (e == 3 || e == 9) begin
        n_checks++;
        if (bus.o_idx !== ((e == 3) ? 2'd1 : 2'd2) || bus.o_busy !== 1'b1) begin
          n_fail++;
          $display("FAIL simul_idx e%0d: got idx %0d busy %b", e, bus.o_idx, bus.o_busy);
        end
      end
    end
  endtask

  task automatic test_release();
    do_reset();
    bus.i_boton = 4'b1000;
    for (int e = 1; e <= 10; e++) tick();
    n_checks++;
    if (bus.o_salida !== 4'b1000) begin
      n_fail++;
      $display("FAIL release_setup: salida %b required 1000", bus.o_salida);
    end
    bus.i_boton = 4'b0000;
    for (int e = 1; e <= 12; e++) begin
      tick();
      n_checks++;
      if (got_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL release e%0d: got %h required %h", e, got_vec(), exp_vec());
      end
      n_checks++;
      if (bus.o_release !== ((e == 8) ? 4'b1000 : 4'b0000) || bus.o_press !== 4'b0000
          || bus.o_salida[3] !== (e < 8)) begin
        n_fail++;
        $display("FAIL release_strobe e%0d: release %b press %b salida %b", e,
                 bus.o_release, bus.o_press, bus.o_salida);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    do_reset();
    bus.i_boton = 4'b0001;
    for (int e = 1; e <= 5; e++) tick();
    n_checks++;
    if (bus.o_conteo !== 8'd2 || bus.o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_setup: conteo %0d busy %b, required 2/1", bus.o_conteo, bus.o_busy);
    end
    reset_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (got_vec() !== '0) begin
      n_fail++;
      $display("FAIL midrst_async: got %h required 0", got_vec());
    end
    tick();
    tick();
    reset_n = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      n_checks++;
      if (got_vec() !== exp_vec() || bus.o_press !== ((e == IMM + 4) ? 4'b0001 : 4'b0000)) begin
        n_fail++;
        $display("FAIL midrst e%0d: got %h required %h press %b", e, got_vec(), exp_vec(),
                 bus.o_press);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) bus.i_boton = bus.i_boton ^ N'($urandom & $urandom);
      if (c == 1700) begin
        reset_n = 1'b0;
        model_reset();
      end
      if (c == 1703) reset_n = 1'b1;
      tick();
      n_checks++;
      if (got_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random c%0d: got %h required %h", c, got_vec(), exp_vec());
      end
      if (m_owner >= 0) begin
        n_checks++;
        if (bus.o_idx !== IW'(m_last)) begin
          n_fail++;
          $display("FAIL random_idx c%0d: got %0d required %0d", c, bus.o_idx, m_last);
        end
      end
      n_checks++;
      if ($countones(bus.o_press | bus.o_release) > 1) begin
        n_fail++;
        $display("FAIL random_onehot c%0d: press %b release %b", c, bus.o_press, bus.o_release);
      end
`ifdef DBNC_EVENT_CNT_EN
      n_checks++;
      if (bus.o_press_count !== 8'(m_pcnt)) begin
        n_fail++;
        $display("FAIL random_pcnt c%0d: got %0d required %0d", c, bus.o_press_count, m_pcnt);
      end
`endif
    end
  endtask

`ifdef DBNC_EVENT_CNT_EN
  task automatic test_event_cnt();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      for (int h = 0; h < 18; h++) begin
        bus.i_boton = (h < 9) ? 4'b0001 : 4'b0000;
        tick();
        n_checks++;
        if (bus.o_press_count !== 8'(m_pcnt) || got_vec() !== exp_vec()) begin
          n_fail++;
          $display("FAIL event_cnt i%0d h%0d: pcnt %0d required %0d, got %h required %h",
                   i, h, bus.o_press_count, m_pcnt, got_vec(), exp_vec());
        end
      end
    end
    n_checks++;
    if (bus.o_press_count !== 8'd255) begin
      n_fail++;
      $display("FAIL event_cnt_sat: got %0d required 255", bus.o_press_count);
    end
  endtask
`endif

  initial begin
    bus.i_boton = '0;
    model_reset();
    test_reset();
    test_single_press();
    test_bounce();
    test_simultaneous();
    test_release();
    test_reset_mid_count();
    test_random();
`ifdef DBNC_EVENT_CNT_EN
    test_event_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
